// File: rtl/cpu_step_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : cpu_step_pkg                                               |
// | Description : Shared definitions for the CPU step controller: FSM state  |
// |               encoding and default timing constants.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cpu_step_pkg;

   // Controller FSM state; the encoding is visible on ctrl_state.
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_STEP  = 2'b01,
      S_RUN   = 2'b10,
      S_BREAK = 2'b11
   } state_t;

   // 20 ms of stable key level at 50 MHz.
   localparam int unsigned c_debounce_cycles_default = 1000000;
   // 10 Hz free-run step rate at 50 MHz.
   localparam int unsigned c_run_div_default         = 5000000;

endpackage : cpu_step_pkg
`default_nettype wire

// File: rtl/cpu_step_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : cpu_step_controller_if                                     |
// | Description : Board-I/O and processor-side signals of the step           |
// |               controller.                                                |
// |   key_step_n  raw step key, active-low, asynchronous                     |
// |   run_sw      mode switch (1 = free run), asynchronous                   |
// |   bp_en       breakpoint enable                                          |
// |   bp_addr     breakpoint PC                                              |
// |   pc_in       current processor PC                                       |
// |   cpu_en      one-cycle processor clock-enable pulse                     |
// |   halted      high while stopped at a breakpoint                         |
// |   ctrl_state  FSM state (IDLE/STEP/RUN/BREAK)                            |
// |   step_count  number of cpu_en pulses issued (wrapping)                  |
// | master = controller side, slave = board/processor side.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface cpu_step_controller_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
);
   logic             key_step_n;
   logic             run_sw;
   logic             bp_en;
   logic [PC_W-1:0]  bp_addr;
   logic [PC_W-1:0]  pc_in;
   logic             cpu_en;
   logic             halted;
   logic [1:0]       ctrl_state;
   logic [CNT_W-1:0] step_count;

   modport master (
      input  key_step_n, run_sw, bp_en, bp_addr, pc_in,
      output cpu_en, halted, ctrl_state, step_count
   );

   modport slave (
      output key_step_n, run_sw, bp_en, bp_addr, pc_in,
      input  cpu_en, halted, ctrl_state, step_count
   );
endinterface : cpu_step_controller_if
`default_nettype wire

// File: rtl/cpu_step_controller_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : step_key_debouncer                                         |
// | Description : 2-flop synchronizer, debounce counter and press detector   |
// |               for the active-low step key.                               |
// |   clk       in   system clock                                            |
// |   in_reset  in   asynchronous reset, active-low                          |
// |   key_n     in   raw key, active-low, asynchronous to clk                |
// |   press     out  one-cycle pulse on each accepted press (1->0)           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module step_key_debouncer
   import cpu_step_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_default
) (
   input  wire logic clk,
   input  wire logic in_reset,
   input  wire logic key_n,
   output logic      press
);

   localparam int unsigned      c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_prev;     // previous synced sample, for change detection
   logic [c_cnt_w-1:0] r_run;      // length of the current run of equal samples
   logic               r_level;    // accepted (debounced) key level
   logic               r_level_d;
   logic               r_press;
   logic [c_cnt_w-1:0] w_run_len;

   // Run length including the current sample; restarts at 1 on any change
   // and saturates once the acceptance threshold is reached.
   always_comb begin
      w_run_len = c_cnt_one;
      if (r_sync2 != r_prev) begin
         w_run_len = c_cnt_one;
      end else if (r_run == c_cnt_max) begin
         w_run_len = c_cnt_max;
      end else begin
         w_run_len = r_run + c_cnt_one;
      end
   end

   always_ff @(posedge clk or negedge in_reset) begin
      if (!in_reset) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_prev    <= 1'b1;
         r_run     <= '0;
         r_level   <= 1'b1;
         r_level_d <= 1'b1;
         r_press   <= 1'b0;
      end else begin
         r_sync1   <= key_n;
         r_sync2   <= r_sync1;
         r_prev    <= r_sync2;
         r_run     <= w_run_len;
         if (w_run_len == c_cnt_max) begin
            r_level <= r_sync2;
         end
         r_level_d <= r_level;
         // Only the falling edge of the accepted level is a press.
         r_press   <= r_level_d & ~r_level;
      end
   end

   assign press = r_press;

endmodule : step_key_debouncer
`default_nettype wire

// File: rtl/cpu_step_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_step_controller                                        |
// | Description : Generates the processor clock-enable. Single-step mode     |
// |               gives one pulse per debounced key press; free-run mode     |
// |               gives one pulse every RUN_DIV clocks. Optional PC          |
// |               breakpoint, enabled by defining STEP_CTRL_BREAKPOINT_EN.   |
// |   clk       in   system clock                                            |
// |   in_reset  in   asynchronous reset, active-low                          |
// |   bus       cpu_step_controller_if.master (key, switch, breakpoint,      |
// |             PC in; cpu_en, halted, ctrl_state, step_count out)           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cpu_step_controller
   import cpu_step_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_default,
   parameter int unsigned RUN_DIV         = c_run_div_default,
   parameter int          PC_W            = 32,
   parameter int          CNT_W           = 16
) (
   input  wire logic               clk,
   input  wire logic               in_reset,
   cpu_step_controller_if.master   bus
);

   localparam int unsigned        c_div_w    = $clog2(RUN_DIV);
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(RUN_DIV - 1);
   localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
   localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

   state_t             r_state;
   logic               r_cpu_en;
   logic               r_halted;
   logic [CNT_W-1:0]   r_count;
   logic [c_div_w-1:0] r_div;
   logic               r_run_s1;
   logic               r_run_s2;
   logic               w_press;
   logic               w_bp_hit;

   step_key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key (
      .clk      (clk),
      .in_reset (in_reset),
      .key_n    (bus.key_step_n),
      .press    (w_press)
   );

   // Bare 2-flop synchronizer for the mode switch.
   always_ff @(posedge clk or negedge in_reset) begin
      if (!in_reset) begin
         r_run_s1 <= 1'b0;
         r_run_s2 <= 1'b0;
      end else begin
         r_run_s1 <= bus.run_sw;
         r_run_s2 <= r_run_s1;
      end
   end

`ifdef STEP_CTRL_BREAKPOINT_EN
   logic [PC_W-1:0] w_pc;
   logic [PC_W-1:0] w_bp_addr;
   assign w_pc      = bus.pc_in;
   assign w_bp_addr = bus.bp_addr;
   assign w_bp_hit  = bus.bp_en && (w_pc == w_bp_addr);
`else
   // Breakpoint inputs are present but have no effect in this build.
   logic [2*PC_W:0] w_unused_bp;
   assign w_unused_bp = {bus.bp_en, bus.bp_addr, bus.pc_in};
   assign w_bp_hit    = 1'b0;
`endif

   always_ff @(posedge clk or negedge in_reset) begin
      if (!in_reset) begin
         r_state  <= S_IDLE;
         r_cpu_en <= 1'b0;
         r_halted <= 1'b0;
         r_count  <= '0;
         r_div    <= '0;
      end else begin
         // Pulses and halted are asserted only by the branch that wants them.
         r_cpu_en <= 1'b0;
         r_halted <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Run mode wins over a coincident press; that press is lost.
               if (r_run_s2) begin
                  r_state <= S_RUN;
                  r_div   <= '0;
               end else if (w_press) begin
                  r_state  <= S_STEP;
                  r_cpu_en <= 1'b1;
                  r_count  <= r_count + c_cnt_one;
               end
            end
            S_STEP: begin
               // The pulse was launched on entry; STEP lasts exactly one cycle.
               r_state <= S_IDLE;
            end
            S_RUN: begin
               if (!r_run_s2) begin
                  r_state <= S_IDLE;
                  r_div   <= '0;
               end else if (r_div == c_div_last) begin
                  r_div <= '0;
                  if (w_bp_hit) begin
                     r_state  <= S_BREAK;
                     r_halted <= 1'b1;
                  end else begin
                     r_cpu_en <= 1'b1;
                     r_count  <= r_count + c_cnt_one;
                  end
               end else begin
                  r_div <= r_div + c_div_one;
               end
            end
`ifdef STEP_CTRL_BREAKPOINT_EN
            S_BREAK: begin
               if (!r_run_s2) begin
                  r_state <= S_IDLE;
               end else if (w_press) begin
                  // Single pulse steps past the breakpoint, then IDLE re-enters RUN.
                  r_state  <= S_STEP;
                  r_cpu_en <= 1'b1;
                  r_count  <= r_count + c_cnt_one;
               end else begin
                  r_halted <= 1'b1;
               end
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_en     = r_cpu_en;
   assign bus.halted     = r_halted;
   assign bus.ctrl_state = r_state;
   assign bus.step_count = r_count;

endmodule : cpu_step_controller
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_step_controller                                     |
// | Description : Self-checking bench for cpu_step_controller. Expected      |
// |               pulses (cycle, step_count) are queued as stimulus is       |
// |               driven and matched against every cpu_en pulse.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cpu_step_controller;
   import cpu_step_pkg::*;

   localparam int D   = 4;
   localparam int RD  = 8;
   localparam int PCW = 32;
   localparam int CW  = 4;

   typedef struct {
      int            cyc;
      logic [CW-1:0] cnt;
   } exp_t;

   logic           clk = 1'b0;
   logic           in_reset;
   int             cyc = 0;
   int             checks = 0;
   int             passed = 0;
   exp_t           q[$];
   logic [CW-1:0]  exp_cnt = '0;
   logic [PCW-1:0] pc_model = '0;
   logic           prev_en = 1'b0;

   cpu_step_controller_if #(.PC_W(PCW), .CNT_W(CW)) bus ();

   cpu_step_controller #(
      .DEBOUNCE_CYCLES (D),
      .RUN_DIV         (RD),
      .PC_W            (PCW),
      .CNT_W           (CW)
   ) dut (
      .clk      (clk),
      .in_reset (in_reset),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // The processor model advances its PC by 4 on each enable pulse.
   assign bus.pc_in = pc_model;

   // Pulse monitor / scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (in_reset === 1'b0) pc_model = '0;
      if (bus.cpu_en === 1'b1) begin
         checks++;
         if (prev_en === 1'b1)
            $display("FAIL cpu_en_single: cycle %0d actual two consecutive highs, required one-cycle pulse", cyc);
         else
            passed++;
         checks++;
         if (q.size() == 0) begin
            $display("FAIL unexpected_pulse: cycle %0d actual pulse (step_count=%0d), required none", cyc, bus.step_count);
         end else begin
            e = q.pop_front();
            if (e.cyc !== cyc || bus.step_count !== e.cnt)
               $display("FAIL pulse: actual cycle %0d count %0d, required cycle %0d count %0d",
                        cyc, bus.step_count, e.cyc, e.cnt);
            else
               passed++;
         end
         pc_model = pc_model + 32'd4;
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
         checks++;
         e = q.pop_front();
         $display("FAIL missing_pulse: cycle %0d actual no pulse, required pulse with count %0d", e.cyc, e.cnt);
      end
      prev_en = bus.cpu_en;
   end

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic neg_of(input int n);
      goto(n);
      if (clk === 1'b1) @(negedge clk);
   endtask

   task automatic push_pulse(input int p);
      exp_t e;
      exp_cnt = exp_cnt + 1'b1;
      e.cyc   = p;
      e.cnt   = exp_cnt;
      q.push_back(e);
   endtask

   // Run mode with RUN first visible in cycle r (divider 0) and run_sw
   // dropped in cycle e: pulses every RD cycles up to cycle e+2.
   task automatic push_run(input int r, input int e);
      for (int p = r + RD; p <= e + 2; p += RD) push_pulse(p);
   endtask

   task automatic do_reset();
      goto(cyc + 1);
      in_reset       = 1'b0;
      bus.key_step_n = 1'b1;
      bus.run_sw     = 1'b0;
      bus.bp_en      = 1'b0;
      bus.bp_addr    = '0;
      exp_cnt        = '0;
      goto(cyc + 2);
      in_reset       = 1'b1;
      goto(cyc + 1);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         goto(cyc + 1);
         bus.key_step_n = i[0];
         bus.run_sw     = ~i[0];
         bus.bp_en      = 1'b1;
         neg_of(cyc);
         checks++;
         if (bus.cpu_en !== 1'b0 || bus.halted !== 1'b0 || bus.ctrl_state !== 2'b00 || bus.step_count !== 4'd0)
            $display("FAIL reset_hold: en=%b halted=%b state=%b count=%0d, required 0/0/00/0",
                     bus.cpu_en, bus.halted, bus.ctrl_state, bus.step_count);
         else
            passed++;
      end
      bus.key_step_n = 1'b1;
      bus.run_sw     = 1'b0;
      bus.bp_en      = 1'b0;
      goto(cyc + 1);
      in_reset = 1'b1;
      neg_of(cyc + 10);
      checks++;
      if (bus.ctrl_state !== 2'b00 || bus.step_count !== 4'd0)
         $display("FAIL reset_release: state=%b count=%0d, required 00/0", bus.ctrl_state, bus.step_count);
      else
         passed++;
   endtask

   task automatic test_debounce();
      int s0, s;
      do_reset();
      s0 = cyc + 1;
      for (int i = 0; i < 6; i++) begin
         goto(s0 + i);
         bus.key_step_n = i[0];
      end
      s = s0 + 6;
      goto(s);
      bus.key_step_n = 1'b0;
      push_pulse(s + D + 4);
      for (int i = 0; i < 6; i++) begin
         goto(s + 12 + i);
         bus.key_step_n = ~i[0];
      end
      goto(s + 18);
      bus.key_step_n = 1'b1;
      neg_of(s + 30);
      checks++;
      if (bus.step_count !== 4'd1 || bus.ctrl_state !== 2'b00)
         $display("FAIL debounce_count: count=%0d state=%b, required 1/00", bus.step_count, bus.ctrl_state);
      else
         passed++;
   endtask

   task automatic test_run();
      int c;
      do_reset();
      c = cyc + 1;
      goto(c);
      bus.run_sw = 1'b1;
      push_run(c + 3, c + 42);
      neg_of(c + 5);
      checks++;
      if (bus.ctrl_state !== 2'b10)
         $display("FAIL run_state: state=%b, required 10", bus.ctrl_state);
      else
         passed++;
      goto(c + 42);
      bus.run_sw = 1'b0;
      neg_of(c + 70);
      checks++;
      if (bus.step_count !== 4'd5 || bus.ctrl_state !== 2'b00)
         $display("FAIL run_count: count=%0d state=%b, required 5/00", bus.step_count, bus.ctrl_state);
      else
         passed++;
   endtask

   task automatic test_breakpoint();
      int c, r, k, r2, e;
      do_reset();
      bus.bp_en   = 1'b1;
      bus.bp_addr = 32'h0000_000C;
      c = cyc + 1;
      goto(c);
      bus.run_sw = 1'b1;
      r = c + 3;
`ifdef STEP_CTRL_BREAKPOINT_EN
      push_pulse(r + 8);
      push_pulse(r + 16);
      push_pulse(r + 24);
      neg_of(r + 33);
      checks++;
      if (bus.halted !== 1'b1 || bus.ctrl_state !== 2'b11)
         $display("FAIL bp_break: halted=%b state=%b, required 1/11", bus.halted, bus.ctrl_state);
      else
         passed++;
      k = r + 45;
      goto(k);
      bus.key_step_n = 1'b0;
      push_pulse(k + D + 4);
      neg_of(k + D + 4);
      checks++;
      if (bus.halted !== 1'b0 || bus.ctrl_state !== 2'b01)
         $display("FAIL bp_step: halted=%b state=%b, required 0/01", bus.halted, bus.ctrl_state);
      else
         passed++;
      r2 = k + D + 6;
      neg_of(r2 + 1);
      checks++;
      if (bus.ctrl_state !== 2'b10)
         $display("FAIL bp_resume: state=%b, required 10", bus.ctrl_state);
      else
         passed++;
      bus.key_step_n = 1'b1;
      e = r2 + 20;
      push_run(r2, e);
`else
      e = c + 60;
      push_run(r, e);
      neg_of(r + 40);
      checks++;
      if (bus.halted !== 1'b0 || bus.ctrl_state !== 2'b10)
         $display("FAIL bp_ignored: halted=%b state=%b, required 0/10", bus.halted, bus.ctrl_state);
      else
         passed++;
`endif
      goto(e);
      bus.run_sw = 1'b0;
      neg_of(e + 12);
      checks++;
      if (bus.ctrl_state !== 2'b00 || bus.step_count !== exp_cnt)
         $display("FAIL bp_end: state=%b count=%0d, required 00/%0d", bus.ctrl_state, bus.step_count, exp_cnt);
      else
         passed++;
      bus.bp_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int c, r, r2, e;
      do_reset();
      c = cyc + 1;
      goto(c);
      bus.run_sw = 1'b1;
      r = c + 3;
      push_pulse(r + 8);          // the pulse at r+16 is cut off by reset
      goto(r + 13);
      in_reset = 1'b0;
      exp_cnt  = '0;
      neg_of(r + 13);
      checks++;
      if (bus.ctrl_state !== 2'b00 || bus.step_count !== 4'd0 || bus.cpu_en !== 1'b0)
         $display("FAIL midreset_clear: state=%b count=%0d en=%b, required 00/0/0",
                  bus.ctrl_state, bus.step_count, bus.cpu_en);
      else
         passed++;
      goto(r + 14);
      in_reset = 1'b1;
      neg_of(r + 16);
      checks++;
      if (bus.cpu_en !== 1'b0 || bus.ctrl_state !== 2'b00)
         $display("FAIL midreset_nopulse: en=%b state=%b, required 0/00", bus.cpu_en, bus.ctrl_state);
      else
         passed++;
      r2 = r + 17;
      e  = r2 + 10;
      push_run(r2, e);
      goto(e);
      bus.run_sw = 1'b0;
      neg_of(e + 12);
      checks++;
      if (bus.step_count !== 4'd1)
         $display("FAIL midreset_rerun: count=%0d, required 1", bus.step_count);
      else
         passed++;
   endtask

   task automatic test_press_and_run_wrap();
      int k, r, e;
      do_reset();
      k = cyc + 1;
      goto(k);
      bus.key_step_n = 1'b0;
      goto(k + D + 1);
      bus.run_sw = 1'b1;
      r = k + D + 4;
      neg_of(r);
      checks++;
      if (bus.ctrl_state !== 2'b10 || bus.cpu_en !== 1'b0)
         $display("FAIL press_run_same: state=%b en=%b, required 10/0", bus.ctrl_state, bus.cpu_en);
      else
         passed++;
      e = r + 127;
      push_run(r, e);
      goto(e);
      bus.run_sw = 1'b0;
      neg_of(e + 10);
      checks++;
      if (bus.step_count !== 4'd0 || bus.ctrl_state !== 2'b00)
         $display("FAIL wrap: count=%0d state=%b, required 0/00", bus.step_count, bus.ctrl_state);
      else
         passed++;
      bus.key_step_n = 1'b1;
      neg_of(e + 30);
   endtask

   initial begin
      in_reset       = 1'b0;
      bus.key_step_n = 1'b1;
      bus.run_sw     = 1'b0;
      bus.bp_en      = 1'b0;
      bus.bp_addr    = '0;
      test_reset();
      test_debounce();
      test_run();
      test_breakpoint();
      test_reset_mid();
      test_press_and_run_wrap();
      neg_of(cyc + 5);
      checks++;
      if (q.size() != 0)
         $display("FAIL scoreboard_drain: %0d expected pulses outstanding, required 0", q.size());
      else
         passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_cpu_step_controller
`default_nettype wire
